// File: rtl/axis_addr_gen_pkg.sv
// Shared definitions for the axis address generator: one-hot state indices,
// the state type, and small constant-evaluable helpers.
package axis_addr_gen_pkg;

  localparam int ST_IDLE  = 0;
  localparam int ST_CALC  = 1;
  localparam int ST_ISSUE = 2;
  localparam int ST_DONE  = 3;

  typedef enum logic [3:0] {
    IDLE  = 4'(1 << ST_IDLE),
    CALC  = 4'(1 << ST_CALC),
    ISSUE = 4'(1 << ST_ISSUE),
    DONE  = 4'(1 << ST_DONE)
  } state_t;

  // Ceiling log2; exact for the power-of-two parameters this block uses.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_addr_gen_if.sv
// Command and AXI address-channel bundle for the address generator.
// master = generator side, slave = command source / AXI slave side.
interface axis_addr_gen_if #(
  parameter int CONFIG_DWIDTH  = 32,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32
);
  logic [CONFIG_DWIDTH-1:0]  cfg_address;
  logic [CONFIG_DWIDTH-1:0]  cfg_length;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic                      axi_aready;
  logic [AXI_ID_WIDTH-1:0]   axi_aid;
  logic [AXI_ADDR_WIDTH-1:0] axi_aaddr;
  logic [AXI_LEN_WIDTH-1:0]  axi_alen;
  logic                      axi_avalid;
  logic                      busy;
  logic                      done;

  modport master (
    input  cfg_address, cfg_length, cfg_valid, axi_aready,
    output cfg_ready, axi_aid, axi_aaddr, axi_alen, axi_avalid, busy, done
  );

  modport slave (
    output cfg_address, cfg_length, cfg_valid, axi_aready,
    input  cfg_ready, axi_aid, axi_aaddr, axi_alen, axi_avalid, busy, done
  );
endinterface

// File: rtl/axis_burst_calc.sv
// Next burst length in beats: the smallest of beats remaining, MAX_BURST and
// the beats left before the next BOUNDARY-aligned address.
module axis_burst_calc
  import axis_addr_gen_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int CNT_WIDTH      = 33,
  parameter int BURST_WIDTH    = 9,
  parameter int MAX_BURST      = 256,
  parameter int BOUNDARY       = 4096,
  parameter int BEAT_BYTES     = 32
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [CNT_WIDTH-1:0]      remaining,
  output logic [BURST_WIDTH-1:0]    burst
);
  localparam int BEAT_LOG = log2(BEAT_BYTES);
  localparam int CMP_W    = max_int(max_int(CNT_WIDTH, log2(BOUNDARY) + 1), BURST_WIDTH);

  logic [AXI_ADDR_WIDTH-1:0] offset;
  logic [CMP_W-1:0]          to_bnd;
  logic [CMP_W-1:0]          room;
  logic [CMP_W-1:0]          cap;

  always_comb begin
    offset = addr & AXI_ADDR_WIDTH'(BOUNDARY - 1);
    to_bnd = CMP_W'(BOUNDARY) - CMP_W'(offset);
    room   = to_bnd >> BEAT_LOG;
    cap    = (room < CMP_W'(MAX_BURST)) ? room : CMP_W'(MAX_BURST);
    burst  = (CMP_W'(remaining) < cap) ? BURST_WIDTH'(remaining) : BURST_WIDTH'(cap);
  end
endmodule

// File: rtl/axis_addr_gen.sv
// Splits a (start address, element count) command into AXI address bursts
// that respect MAX_BURST and never cross a BOUNDARY-aligned address.
//
// state | meaning
// IDLE  | waiting for a command, cfg_ready high
// CALC  | size the next burst, or finish when nothing remains
// ISSUE | hold axi_avalid with address/length until axi_aready
// DONE  | one-cycle done pulse, then back to IDLE
module axis_addr_gen
  import axis_addr_gen_pkg::*;
#(
  parameter int CONFIG_DWIDTH  = 32,
  parameter int WIDTH_RATIO    = 16,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int MAX_BURST      = 256,
  parameter int BOUNDARY       = 4096
) (
  input logic              clk,
  input logic              rst,
  axis_addr_gen_if.master  bus
);
  localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
  localparam int BEAT_LOG   = log2(BEAT_BYTES);
  localparam int RATIO_LOG  = log2(WIDTH_RATIO);
  localparam int CNT_W      = CONFIG_DWIDTH + 1;
  localparam int BURST_W    = log2(MAX_BURST) + 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BEAT_BYTES - 1);

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [CNT_W-1:0]          remaining;
  logic [BURST_W-1:0]        burst;
  logic [BURST_W-1:0]        next_burst;
  logic [AXI_ID_WIDTH-1:0]   aid;
  logic [AXI_ADDR_WIDTH-1:0] aaddr;
  logic [AXI_LEN_WIDTH-1:0]  alen;
  logic                      avalid;
  logic                      cfg_ready;
  logic                      busy;
  logic                      done;

  axis_burst_calc #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .CNT_WIDTH      (CNT_W),
    .BURST_WIDTH    (BURST_W),
    .MAX_BURST      (MAX_BURST),
    .BOUNDARY       (BOUNDARY),
    .BEAT_BYTES     (BEAT_BYTES)
  ) u_burst_calc (
    .addr      (addr),
    .remaining (remaining),
    .burst     (next_burst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      burst     <= '0;
      aid       <= '0;
      aaddr     <= '0;
      alen      <= '0;
      avalid    <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cfg_valid) begin
            addr      <= AXI_ADDR_WIDTH'(bus.cfg_address) & ALIGN_MASK;
            // One extra bit keeps the round-up sum from overflowing.
            remaining <= (CNT_W'(bus.cfg_length) + CNT_W'(WIDTH_RATIO - 1)) >> RATIO_LOG;
            aid       <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            burst  <= next_burst;
            aaddr  <= addr;
            alen   <= AXI_LEN_WIDTH'(next_burst - BURST_W'(1));
            avalid <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.axi_aready) begin
            avalid    <= 1'b0;
            addr      <= addr + (AXI_ADDR_WIDTH'(burst) << BEAT_LOG);
            remaining <= remaining - CNT_W'(burst);
            aid       <= aid + AXI_ID_WIDTH'(1);
            if (remaining == CNT_W'(burst)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          avalid    <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          cfg_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_ready  = cfg_ready;
  assign bus.axi_aid    = aid;
  assign bus.axi_aaddr  = aaddr;
  assign bus.axi_alen   = alen;
  assign bus.axi_avalid = avalid;
  assign bus.busy       = busy;
  assign bus.done       = done;
endmodule

// File: doc/axis_addr_gen.md
AXIS_ADDR_GEN -- requirements
Module: axis_addr_gen

Interface
REQ-001 SHALL have parameter CONFIG_DWIDTH, default 32, width of the cfg address and cfg length fields.
REQ-002 SHALL have parameter WIDTH_RATIO, default 16, stream elements per AXI beat; power of two.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 8; AXI_LEN_WIDTH, default 8; AXI_ADDR_WIDTH, default 32; AXI_DATA_WIDTH, default 256.
REQ-004 SHALL have parameter MAX_BURST, default 256, maximum beats per burst; power of two, no greater than 2^AXI_LEN_WIDTH.
REQ-005 SHALL have parameter BOUNDARY, default 4096, byte boundary no burst may cross; power of two, no smaller than AXI_DATA_WIDTH/8.
REQ-006 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); reset rst, synchronous, active-high; clock clk.
REQ-007 SHALL have ports cfg_address (in, CONFIG_DWIDTH, start byte address), cfg_length (in, CONFIG_DWIDTH, stream elements), cfg_valid (in, 1) and cfg_ready (out, 1).
REQ-008 SHALL have ports axi_aready (in, 1), axi_aid (out, AXI_ID_WIDTH), axi_aaddr (out, AXI_ADDR_WIDTH), axi_alen (out, AXI_LEN_WIDTH) and axi_avalid (out, 1).
REQ-009 SHALL have ports busy (out, 1, command in progress) and done (out, 1, one-cycle completion pulse).

Function
REQ-010 SHALL be a one-hot FSM with states IDLE, CALC, ISSUE and DONE.
REQ-011 cfg_ready SHALL be 1 only in IDLE; a command is accepted when cfg_valid is high and cfg_ready is high.
REQ-012 On accept, SHALL latch addr = cfg_address with the low log2(AXI_DATA_WIDTH/8) bits cleared.
REQ-013 On accept, SHALL latch remaining = (cfg_length + WIDTH_RATIO - 1) >> log2(WIDTH_RATIO), computed CONFIG_DWIDTH+1 bits wide so the sum cannot overflow.
REQ-014 On accept, SHALL clear axi_aid to 0.
REQ-015 On accept, SHALL go to CALC.
REQ-016 In CALC, with remaining = 0, SHALL go to DONE and SHALL NOT assert axi_avalid.
REQ-017 In CALC, with remaining > 0, SHALL register burst = min(remaining, MAX_BURST, (BOUNDARY - (addr mod BOUNDARY)) / (AXI_DATA_WIDTH/8)).
REQ-018 In CALC, with remaining > 0, SHALL then go to ISSUE.
REQ-019 In ISSUE, axi_avalid SHALL be 1, axi_aaddr SHALL equal addr, and axi_alen SHALL equal burst - 1.
REQ-020 axi_aaddr and axi_alen SHALL be stable while axi_avalid is high and axi_aready is low.
REQ-021 On axi_aready in ISSUE: addr += burst * (AXI_DATA_WIDTH/8); remaining -= burst; axi_aid increments, wrapping modulo 2^AXI_ID_WIDTH.
REQ-022 On axi_aready in ISSUE, SHALL go to DONE if the new remaining is 0, otherwise to CALC.
REQ-023 Consecutive bursts SHALL therefore be spaced at least 2 cycles apart.
REQ-024 DONE SHALL assert done for exactly 1 cycle, then go to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 cfg_valid outside IDLE SHALL be ignored.
REQ-027 Address arithmetic SHALL wrap modulo 2^AXI_ADDR_WIDTH.
REQ-028 Any illegal or zero state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-029 While rst is high, the FSM SHALL enter IDLE on the next clk edge.
REQ-030 During reset, axi_avalid = 0, done = 0, busy = 0, cfg_ready = 1, axi_aid = 0, axi_aaddr = 0, axi_alen = 0.
REQ-031 Reset asserted mid-command SHALL abandon the command; no further bursts or done pulse SHALL follow.

Structure
REQ-032 SHALL place the state indices and the log2 helper function in the shared axis defines include file used by all axis blocks.
REQ-033 SHALL compute burst length in a single combinational sub-module, axis_burst_calc (inputs addr and remaining; output burst), instantiated once.

Verification (AXI_DATA_WIDTH = 256, 32 B/beat, BOUNDARY = 4096, MAX_BURST = 256)
REQ-034 Addr 0x0000, length 4800 -> 300 beats -> bursts at 0x0000, 0x1000, 0x2000 with alen 127, 127, 43; aid 0, 1, 2; then one done pulse.
REQ-035 Addr 0x0F80, length 160 -> bursts at 0x0F80 alen 3, then 0x1000 alen 5.
REQ-036 Addr 0x0000, length 17 -> one burst, alen 1; length 0 -> no avalid, done pulse 2 cycles after accept.
REQ-037 axi_aready held low 10 cycles during ISSUE -> avalid, aaddr, alen and aid held constant; the burst completes on the first aready cycle.
REQ-038 MAX_BURST = 16, addr 0x0000, length 640 -> 40 beats -> bursts alen 15, 15, 7 at 0x000, 0x200, 0x400.
REQ-039 rst asserted during the second burst of REQ-034 -> next cycle avalid = 0, cfg_ready = 1, no done pulse; a new command then runs normally with aid starting at 0.
